// File: rtl/post_processing_ctrl.sv
// post_processing_ctrl
//   Frame sequencer for the six-to-one feature reduction pipeline. Admits
//   exactly one ROWS x COLS frame of conv beats after a start command, tracks
//   each admitted beat through the fixed pipeline latency, and tags the
//   pipeline output with row/column position and end-of-row/frame markers.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   start          one-cycle frame start request (honoured only in IDLE)
//   features_valid conv layer presents a beat to the pipeline this cycle
//   out_valid      pipeline output carries a frame beat this cycle
//   out_row        row of the current output beat
//   out_col        column of the current output beat
//   out_last_col   output beat is the last column of its row
//   out_last_frame output beat is the final beat of the frame
//   busy           frame in progress (RUN or FLUSH)
//   done           one-cycle pulse after the last output beat
//   err_stray      sticky: beat presented while none was admissible
module post_processing_ctrl #(
    parameter int unsigned ROWS       = 28,
    parameter int unsigned COLS       = 28,
    parameter int unsigned PP_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    features_valid,
    output logic                    out_valid,
    output logic [$clog2(ROWS)-1:0] out_row,
    output logic [$clog2(COLS)-1:0] out_col,
    output logic                    out_last_col,
    output logic                    out_last_frame,
    output logic                    busy,
    output logic                    done,
    output logic                    err_stray
);

    localparam int unsigned TOTAL = ROWS * COLS;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FULL_IN  = CNT_W'(TOTAL);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [PP_LATENCY-1:0]   vld_sr_q, vld_sr_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    admit;

    assign out_valid      = vld_sr_q[PP_LATENCY-1];
    assign out_row        = row_q;
    assign out_col        = col_q;
    assign out_last_col   = out_valid && (col_q == LAST_COL);
    assign out_last_frame = out_last_col && (row_q == LAST_ROW);
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_stray      = err_q;

    // Only RUN admits beats; the count guard is redundant with the RUN->FLUSH
    // transition but keeps the counter from ever passing the frame total.
    assign admit = (state_q == RUN) && features_valid && (in_cnt_q != FULL_IN);

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        err_d    = err_q;

        vld_sr_d[0] = admit;
        for (int unsigned i = 1; i < PP_LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        // Position advances per output beat; it holds on the final beat so the
        // row counter never steps past ROWS-1.
        if (out_valid && !out_last_frame) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    in_cnt_d = '0;
                    row_d    = '0;
                    col_d    = '0;
                    err_d    = 1'b0;
                end
            end
            RUN: begin
                if (admit) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == LAST_IN) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_last_frame) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stray beat flags even on the start edge: that beat is itself stray.
        if (features_valid && (state_q != RUN)) begin
            err_d = 1'b1;
        end

        busy_d = (state_d == RUN) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            in_cnt_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
            vld_sr_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            vld_sr_q <= vld_sr_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_post_processing_ctrl.sv
module tb_post_processing_ctrl;

    localparam int unsigned ROWS = 2;
    localparam int unsigned COLS = 3;
    localparam int unsigned LAT  = 4;
    localparam int unsigned NBEATS = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       features_valid;
    logic       out_valid;
    logic [0:0] out_row;
    logic [1:0] out_col;
    logic       out_last_col;
    logic       out_last_frame;
    logic       busy;
    logic       done;
    logic       err_stray;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;

    typedef struct {
        int unsigned due;
        int unsigned row;
        int unsigned col;
        bit          lc;
        bit          lf;
    } exp_t;

    exp_t sb[$];

    post_processing_ctrl #(
        .ROWS(ROWS),
        .COLS(COLS),
        .PP_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .features_valid(features_valid),
        .out_valid(out_valid),
        .out_row(out_row),
        .out_col(out_col),
        .out_last_col(out_last_col),
        .out_last_frame(out_last_frame),
        .busy(busy),
        .done(done),
        .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_n === 1'b1 && done === 1'b1) done_cnt <= done_cnt + 1;

    // Scoreboard consumer: every out_valid beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid cyc=%0d out_valid=%b row=%0d col=%0d required no beat",
                         cyc, out_valid, out_row, out_col);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.due || 32'(out_row) !== e.row || 32'(out_col) !== e.col ||
                    out_last_col !== e.lc || out_last_frame !== e.lf) begin
                    errors++;
                    $display("FAIL out_beat got cyc=%0d row=%0d col=%0d lc=%b lf=%b required cyc=%0d row=%0d col=%0d lc=%b lf=%b",
                             cyc, out_row, out_col, out_last_col, out_last_frame,
                             e.due, e.row, e.col, e.lc, e.lf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int unsigned idx);
        exp_t e;
        e.due = cyc + LAT;
        e.row = idx / COLS;
        e.col = idx % COLS;
        e.lc  = (e.col == COLS - 1);
        e.lf  = (idx == NBEATS - 1);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        features_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_row, out_col, out_last_col, out_last_frame, busy, done, err_stray} !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs got v=%b r=%0d c=%0d lc=%b lf=%b busy=%b done=%b err=%b required all 0",
                         out_valid, out_row, out_col, out_last_col, out_last_frame, busy, done, err_stray);
            end
        end
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        features_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err_stray !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b err=%b required 0 0", busy, err_stray);
        end
        tick();
    endtask

    // Full-rate frame relative to the start cycle k=0; optional start pokes in
    // RUN (k=3) and DONE (k=11) and an optional overrun beat in FLUSH (k=7).
    task automatic full_frame(input bit poke, input bit extra, input string name);
        int unsigned d0;
        int unsigned idx;
        logic exp_b;
        d0  = done_cnt;
        idx = 0;
        for (int k = 0; k <= 14; k++) begin
            start = (k == 0) || (poke && (k == 3 || k == 11));
            features_valid = (k >= 1 && k <= 6) || (extra && k == 7);
            if (k >= 1 && k <= 6) begin
                push_beat(idx);
                idx++;
            end
            @(negedge clk);
            exp_b = (k >= 1 && k <= 10);
            checks++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL %s_busy k=%0d got %b required %b", name, k, busy, exp_b);
            end
            exp_b = (k == 11);
            checks++;
            if (done !== exp_b) begin
                errors++;
                $display("FAIL %s_done k=%0d got %b required %b", name, k, done, exp_b);
            end
            if (k >= 1) begin
                exp_b = extra && (k >= 8);
                checks++;
                if (err_stray !== exp_b) begin
                    errors++;
                    $display("FAIL %s_err_stray k=%0d got %b required %b", name, k, err_stray, exp_b);
                end
            end
            tick();
        end
        start = 1'b0;
        features_valid = 1'b0;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s_done_count got %0d required 1", name, done_cnt - d0);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending_beats got %0d required 0", name, sb.size());
        end
    endtask

    task automatic test_full_rate();
        full_frame(1'b0, 1'b0, "full_rate");
    endtask

    task automatic test_gapped();
        int unsigned d0;
        int unsigned t;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int unsigned i = 0; i < NBEATS; i++) begin
            repeat ($urandom_range(3, 0)) tick();
            features_valid = 1'b1;
            push_beat(i);
            tick();
            features_valid = 1'b0;
        end
        t = 0;
        while (done_cnt == d0 && t < 40) begin
            tick();
            t++;
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL gapped_done got %0d done pulses required 1 within 40 cycles", done_cnt - d0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL gapped_end got busy=%b pending=%0d required 0 0", busy, sb.size());
        end
        tick();
    endtask

    task automatic test_stray_overrun();
        features_valid = 1'b1;
        tick();
        features_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_stray !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle got err=%b busy=%b required 1 0", err_stray, busy);
        end
        tick();
        tick();
        full_frame(1'b0, 1'b1, "overrun");
        @(negedge clk);
        checks++;
        if (err_stray !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b required 1", err_stray);
        end
        tick();
    endtask

    // The start at k=0 of this frame must also clear the err_stray left by the
    // overrun test (checked as 0 from k=1 inside full_frame).
    task automatic test_ignored_start();
        full_frame(1'b1, 1'b0, "ignored_start");
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            features_valid = 1'b1;
            push_beat(i);
            tick();
        end
        features_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_row, out_col, out_last_col, out_last_frame, busy, done, err_stray} !== 10'b0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b r=%0d c=%0d lc=%b lf=%b busy=%b done=%b err=%b required all 0",
                     out_valid, out_row, out_col, out_last_col, out_last_frame, busy, done, err_stray);
        end
        repeat (6) tick();
        full_frame(1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        features_valid = 1'b0;
        test_reset();
        test_full_rate();
        test_gapped();
        test_stray_overrun();
        test_ignored_start();
        test_reset_mid_frame();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
